// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 control-port sequencer: FSM states,
// SPI frame layout, codec register addresses and the power-up register table.
package ad9866_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        INIT_LOAD,
        SHIFT,
        GUARD,
        IDLE
    } state_e;

    localparam int FRAME_W = 16;
    localparam int RW_POS  = 15;
    localparam int ADDR_HI = 14;
    localparam int ADDR_LO = 9;
    localparam int DATA_HI = 7;

    localparam logic [5:0] ADDR_PWR_DN  = 6'h01;
    localparam logic [5:0] ADDR_CLK_CFG = 6'h04;
    localparam logic [5:0] ADDR_PGA     = 6'h09;
    localparam logic [5:0] ADDR_TX_GAIN = 6'h12;

    // Each entry is {addr[5:0], data[7:0]}, written in order after reset.
    localparam int INIT_TABLE_LEN = 8;
    localparam logic [13:0] INIT_TABLE [INIT_TABLE_LEN] = '{
        {ADDR_CLK_CFG, 8'h36},
        {ADDR_PWR_DN,  8'h00},
        {6'h06,        8'h1C},
        {6'h07,        8'h04},
        {6'h0D,        8'h41},
        {6'h0E,        8'h81},
        {ADDR_PGA,     8'h40},
        {ADDR_TX_GAIN, 8'h3F}
    };

    function automatic logic [FRAME_W-1:0] make_frame(input logic       rd,
                                                      input logic [5:0] addr,
                                                      input logic [7:0] data);
        logic [FRAME_W-1:0] f;
        f                  = '0;
        f[RW_POS]          = rd;
        f[ADDR_HI:ADDR_LO] = addr;
        if (!rd) f[DATA_HI:0] = data;
        return f;
    endfunction

endpackage

// File: rtl/ad9866_init_rom.sv
// Combinational power-up register table: index -> {addr, data}.
// Entries beyond the built-in table read back as a write of 0x00 to address 0.
module ad9866_init_rom
    import ad9866_pkg::*;
#(
    parameter int INIT_LEN = 8,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0] index,
    output logic [5:0]       addr,
    output logic [7:0]       data
);

    logic [13:0] entry;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        entry = '0;
        for (int i = 0; i < INIT_TABLE_LEN; i++) begin
            if (i < INIT_LEN && index == IDX_W'(i)) entry = INIT_TABLE[i];
        end
    end

    assign addr = entry[13:8];
    assign data = entry[7:0];

endmodule

// File: rtl/ad9866_ctrl.sv
// AD9866 control-port sequencer: codec hardware reset, settle delay, init table
// write-out, then single register read/write commands over a 16-bit SPI frame.
module ad9866_ctrl
    import ad9866_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 64,
    parameter int WAIT_CYCLES = 1024,
    parameter int INIT_LEN    = 8
) (
    input  logic       ad9866spiclk,
    input  logic       rst_n,
    input  logic       reinit,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       init_done,
    output logic       busy,
    output logic       ad9866_rst_n,
    output logic       ad9866_sclk,
    output logic       ad9866_sdio,
    input  logic       ad9866_sdo,
    output logic       ad9866_sen_n
);

    localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES)
                           ? ((RST_CYCLES > 2 * CLK_DIV) ? RST_CYCLES : 2 * CLK_DIV)
                           : ((WAIT_CYCLES > 2 * CLK_DIV) ? WAIT_CYCLES : 2 * CLK_DIV);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int IDX_W = (INIT_LEN < 1) ? 1 : $clog2(INIT_LEN + 1);

    // INIT_LOAD takes one cycle, so RST_WAIT ends a cycle early when a table is
    // written; ad9866_rst_n is then high for exactly WAIT_CYCLES before SEN falls.
    localparam int WAIT_END = (INIT_LEN == 0) ? WAIT_CYCLES - 1
                            : ((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_END);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(INIT_LEN);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [3:0]         bit_q,       bit_d;
    logic [IDX_W-1:0]   index_q,     index_d;
    logic [IDX_W-1:0]   idx_next;
    logic [FRAME_W-1:0] shreg_q,     shreg_d;
    logic               rd_op_q,     rd_op_d;
    logic               in_init_q,   in_init_d;
    logic [6:0]         rd_shift_q,  rd_shift_d;
    logic [7:0]         rd_data_q,   rd_data_d;
    logic               rd_valid_q,  rd_valid_d;
    logic               init_done_q, init_done_d;

    logic [5:0]         rom_addr;
    logic [7:0]         rom_data;

    ad9866_init_rom #(
        .INIT_LEN (INIT_LEN),
        .IDX_W    (IDX_W)
    ) u_rom (
        .index (index_q),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge ad9866spiclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            bit_q       <= '0;
            index_q     <= '0;
            shreg_q     <= '0;
            rd_op_q     <= 1'b0;
            in_init_q   <= 1'b0;
            rd_shift_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            index_q     <= index_d;
            shreg_q     <= shreg_d;
            rd_op_q     <= rd_op_d;
            in_init_q   <= in_init_d;
            rd_shift_q  <= rd_shift_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        index_d     = index_q;
        idx_next    = index_q + 1'b1;
        shreg_d     = shreg_q;
        rd_op_d     = rd_op_q;
        in_init_d   = in_init_q;
        rd_shift_d  = rd_shift_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        init_done_d = init_done_q;

        case (state_q)
            RST_HOLD: begin
                init_done_d = 1'b0;
                if (cnt_q == RST_LAST) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                end
            end

            RST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    index_d = '0;
                    if (INIT_LEN == 0) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = INIT_LOAD;
                    end
                end
            end

            INIT_LOAD: begin
                shreg_d   = make_frame(1'b0, rom_addr, rom_data);
                rd_op_d   = 1'b0;
                in_init_d = 1'b1;
                bit_d     = '0;
                cnt_d     = '0;
                state_d   = SHIFT;
            end

            SHIFT: begin
                // Bit boundary is the last SCLK-high cycle: sample SDO, advance SDIO.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    if (rd_op_q && bit_q >= 4'd8) rd_shift_d = {rd_shift_q[5:0], ad9866_sdo};
                    if (bit_q == 4'd15) begin
                        state_d = GUARD;
                        if (rd_op_q) begin
                            rd_data_d  = {rd_shift_q, ad9866_sdo};
                            rd_valid_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d = '0;
                    if (!in_init_q) begin
                        state_d = IDLE;
                    end else if (idx_next < IDX_END) begin
                        index_d = idx_next;
                        state_d = INIT_LOAD;
                    end else begin
                        index_d     = idx_next;
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            IDLE: begin
                cnt_d = '0;
                if (reinit) begin
                    init_done_d = 1'b0;
                    state_d     = RST_HOLD;
                end else if (cmd_valid) begin
                    shreg_d   = make_frame(cmd_rd, cmd_addr, cmd_data);
                    rd_op_d   = cmd_rd;
                    in_init_d = 1'b0;
                    bit_d     = '0;
                    state_d   = SHIFT;
                end
            end

            default: begin
                state_d = RST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Pins decode registered state only, so an async reset forces them at once.
    assign ad9866_rst_n = (state_q != RST_HOLD);
    assign ad9866_sen_n = (state_q != SHIFT);
    assign ad9866_sclk  = (state_q == SHIFT) && (cnt_q >= HALF);
    assign ad9866_sdio  = (state_q == SHIFT) && shreg_q[FRAME_W-1];

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;

endmodule
